// File: rtl/vco_ms_readout.sv
// Multi-channel ring-oscillator VCO-ADC readout: synchronises the taps, counts coarse
// cycles, snapshots the fine phase on a refresh tick and serialises the results per channel.
module vco_ms_readout #(
    parameter int NumChannels = 2,
    parameter int NumPhases   = 31,
    parameter int CoarseWidth = 26,
    parameter int FineWidth   = 5,
    parameter int PeriodWidth = 16,
    localparam int ChWidth    = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             en_i,
    input  logic                             continuous_i,
    input  logic                             start_i,
    input  logic [PeriodWidth-1:0]           period_i,
    input  logic [NumChannels*NumPhases-1:0] vco_phase_i,
    output logic [CoarseWidth+FineWidth-1:0] data_o,
    output logic [ChWidth-1:0]               ch_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic                             busy_o,
    output logic                             overflow_o,
    input  logic                             clr_overflow_i
);

    typedef enum logic {StIdle, StEmit} state_e;

    state_e                 state_q, state_d;
    logic [ChWidth-1:0]     k_q, k_d;
    logic                   ovf_q, ovf_d;
    logic                   en_q;
    logic                   armed_q, armed_d;
    logic [PeriodWidth-1:0] timer_q, timer_d;
    logic [PeriodWidth-1:0] pm1_q, pm1_d;
    logic [PeriodWidth-1:0] period_m1;
    logic                   tick;
    logic                   capture;
    logic                   drop;
    logic                   fire;
    logic                   last_beat;

    logic [CoarseWidth-1:0] delta_w [NumChannels];
    logic [FineWidth-1:0]   fine_w  [NumChannels];

    assign period_m1 = (period_i == '0) ? '0 : period_i - PeriodWidth'(1);

    // Refresh timer; the enable rising cycle restarts it so the first window is a full period.
    always_comb begin
        timer_d = timer_q;
        pm1_d   = pm1_q;
        armed_d = armed_q;
        tick    = 1'b0;
        if (!en_i || !en_q) begin
            timer_d = '0;
            armed_d = 1'b0;
            pm1_d   = period_m1;
        end else if (continuous_i) begin
            armed_d = 1'b0;
            if (timer_q == pm1_q) begin
                tick    = 1'b1;
                timer_d = '0;
                pm1_d   = period_m1;
            end else begin
                timer_d = timer_q + PeriodWidth'(1);
            end
        end else if (armed_q) begin
            if (timer_q == pm1_q) begin
                tick    = 1'b1;
                armed_d = 1'b0;
                timer_d = '0;
            end else begin
                timer_d = timer_q + PeriodWidth'(1);
            end
        end else if (start_i) begin
            armed_d = 1'b1;
            timer_d = '0;
            pm1_d   = period_m1;
        end else begin
            timer_d = '0;
        end
    end

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
        logic [NumPhases-1:0]   sync1_q, sync2_q;
        logic                   tap0_prev_q;
        logic [CoarseWidth-1:0] cnt_q, cnt_prev_q, delta_q;
        logic [FineWidth-1:0]   fine_q;
        logic [FineWidth-1:0]   pop;
        logic                   rise;

        always_comb begin
            pop = '0;
            for (int i = 0; i < NumPhases; i++) begin
                pop = pop + FineWidth'(sync2_q[i]);
            end
        end

        assign rise = sync2_q[0] & ~tap0_prev_q;

        // cnt_q is read before this cycle's edge is added, so a tick-cycle edge goes to the next sample.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync1_q     <= '0;
                sync2_q     <= '0;
                tap0_prev_q <= 1'b0;
                cnt_q       <= '0;
                cnt_prev_q  <= '0;
                delta_q     <= '0;
                fine_q      <= '0;
            end else begin
                sync1_q     <= vco_phase_i[gi*NumPhases +: NumPhases];
                sync2_q     <= sync1_q;
                tap0_prev_q <= sync2_q[0];
                if (!en_i) begin
                    cnt_q      <= '0;
                    cnt_prev_q <= '0;
                    delta_q    <= '0;
                    fine_q     <= '0;
                end else begin
                    cnt_q <= cnt_q + CoarseWidth'(rise);
                    if (!en_q || tick) begin
                        cnt_prev_q <= cnt_q;
                    end
                    if (capture) begin
                        delta_q <= cnt_q - cnt_prev_q;
                        fine_q  <= pop;
                    end
                end
            end
        end

        assign delta_w[gi] = delta_q;
        assign fine_w[gi]  = fine_q;
    end

    assign fire      = (state_q == StEmit) && ready_i;
    assign last_beat = (k_q == ChWidth'(NumChannels - 1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ovf_d   = ovf_q;
        capture = 1'b0;
        drop    = 1'b0;
        if (!en_i) begin
            state_d = StIdle;
            k_d     = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (tick) begin
                        capture = 1'b1;
                        state_d = StEmit;
                        k_d     = '0;
                    end
                end
                StEmit: begin
                    if (fire) begin
                        if (last_beat) begin
                            k_d = '0;
                            if (tick) begin
                                capture = 1'b1;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            k_d = k_q + ChWidth'(1);
                        end
                    end
                    // A snapshot can only be replaced once its last beat has been taken.
                    if (tick && !(fire && last_beat)) begin
                        drop = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            k_q     <= '0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
            armed_q <= 1'b0;
            timer_q <= '0;
            pm1_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
            en_q    <= en_i;
            armed_q <= armed_d;
            timer_q <= timer_d;
            pm1_q   <= pm1_d;
        end
    end

    assign valid_o    = (state_q == StEmit);
    assign busy_o     = (state_q == StEmit);
    assign ch_o       = k_q;
    assign data_o     = {delta_w[k_q], fine_w[k_q]};
    assign overflow_o = ovf_q;

endmodule
